// File: rtl/magnetron_pkg.sv
// Shared definitions for the magnetron control: FSM state encodings, the default
// number of power steps and the power-level clamp.
package magnetron_pkg;

  localparam int LEVELS_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // A request of 0 or anything above the top step means full power.
  function automatic int unsigned clamp_level(input int unsigned level,
                                              input int unsigned levels);
    return ((level == 0) || (level > levels)) ? levels : level;
  endfunction

endpackage

// File: rtl/controle_magnetron_pwm_gerador.sv
// gerador_pwm: phase counter over a LEVELS-cycle window, power latch and the
// registered duty-cycle compare that drives the magnetron in RUN.
module gerador_pwm #(
  parameter int LEVELS  = 10,
  parameter int LEVEL_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               run,
  input  logic               run_entry,
  input  logic [LEVEL_W-1:0] eff_level,
  output logic               pwm_on
);

  localparam int PH_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  logic [PH_W-1:0]    r_phase;
  logic [LEVEL_W-1:0] r_level_q;
  logic               r_pwm_on;
  logic [PH_W-1:0]    w_phase_next;
  logic [LEVEL_W-1:0] w_level_next;
  logic               w_wrap;

  // The level is only re-sampled at a window boundary so a window never changes duty midway.
  always_comb begin
    w_wrap       = (r_phase == PH_W'(LEVELS - 1));
    w_phase_next = w_wrap ? '0 : r_phase + PH_W'(1);
    w_level_next = w_wrap ? eff_level : r_level_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_phase   <= '0;
      r_level_q <= LEVEL_W'(LEVELS);
      r_pwm_on  <= 1'b0;
    end else if (run_entry) begin
      r_phase   <= '0;
      r_level_q <= eff_level;
      r_pwm_on  <= (eff_level != '0);
    end else if (run) begin
      r_phase   <= w_phase_next;
      r_level_q <= w_level_next;
      r_pwm_on  <= (32'(w_phase_next) < 32'(w_level_next));
    end else begin
      r_phase  <= '0;
      r_pwm_on <= 1'b0;
    end
  end

  assign pwm_on = r_pwm_on;

endmodule

// File: rtl/controle_magnetron_pwm.sv
// Magnetron control FSM (IDLE/RUN/PAUSE) with a combinational door safety gate.
// Define MAGNETRON_PWM_EN to build the power-level duty cycle; otherwise RUN means full power.
module controle_magnetron_pwm
  import magnetron_pkg::*;
#(
  parameter int LEVELS  = LEVELS_DEFAULT,
  parameter int LEVEL_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               startn,
  input  logic               stopn,
  input  logic               clearn,
  input  logic               door_closed,
  input  logic               timer_done,
  input  logic [LEVEL_W-1:0] power_level,
  output logic               mag_on,
  output logic               running,
  output logic               paused
);

  state_t r_state;
  state_t w_next;
  logic   r_running;
  logic   r_paused;
  logic   w_mag_q;
  logic   w_run;
  logic   w_run_entry;

  // Priority: clear > timer done > stop or open door > start.
  always_comb begin
    w_next = r_state;
    if (!clearn || timer_done) begin
      w_next = ST_IDLE;
    end else if (!stopn || !door_closed) begin
      w_next = (r_state == ST_IDLE) ? ST_IDLE : ST_PAUSE;
    end else if (!startn) begin
      w_next = ST_RUN;
    end
  end

  assign w_run       = (w_next == ST_RUN);
  assign w_run_entry = w_run && (r_state != ST_RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_paused  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_running <= (w_next == ST_RUN);
      r_paused  <= (w_next == ST_PAUSE);
    end
  end

`ifdef MAGNETRON_PWM_EN
  logic [LEVEL_W-1:0] w_eff_level;

  assign w_eff_level = LEVEL_W'(clamp_level(32'(power_level), LEVELS));

  gerador_pwm #(
    .LEVELS  (LEVELS),
    .LEVEL_W (LEVEL_W)
  ) u_gerador_pwm (
    .clk       (clk),
    .resetn    (resetn),
    .run       (w_run),
    .run_entry (w_run_entry),
    .eff_level (w_eff_level),
    .pwm_on    (w_mag_q)
  );
`else
  logic r_mag_q;
  logic w_unused_power;

  assign w_unused_power = ^{power_level, w_run_entry};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mag_q <= 1'b0;
    end else begin
      r_mag_q <= w_run;
    end
  end

  assign w_mag_q = r_mag_q;
`endif

  // The door gate stays combinational so opening the door cuts power within the same cycle.
  assign mag_on  = w_mag_q & door_closed;
  assign running = r_running;
  assign paused  = r_paused;

endmodule

// File: tb/tb_controle_magnetron_pwm.sv
// Self-checking bench for controle_magnetron_pwm against a cycle-count reference model;
// follows MAGNETRON_PWM_EN so the expected duty matches the build.
module tb_controle_magnetron_pwm;

  localparam int LEVELS  = 10;
  localparam int LEVEL_W = 4;
`ifdef MAGNETRON_PWM_EN
  localparam bit PWM_EN = 1'b1;
`else
  localparam bit PWM_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               resetn;
  logic               startn;
  logic               stopn;
  logic               clearn;
  logic               door_closed;
  logic               timer_done;
  logic [LEVEL_W-1:0] power_level;
  logic               mag_on;
  logic               running;
  logic               paused;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: mode name, cycles spent in RUN since entry, level of the current window.
  string mMode      = "IDLE";
  int    runCycles  = 0;
  int    winLevel   = LEVELS;

  controle_magnetron_pwm #(
    .LEVELS  (LEVELS),
    .LEVEL_W (LEVEL_W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .timer_done  (timer_done),
    .power_level (power_level),
    .mag_on      (mag_on),
    .running     (running),
    .paused      (paused)
  );

  always #5 clk = ~clk;

  function automatic int effLevel(input int p);
    return (p == 0 || p > LEVELS) ? LEVELS : p;
  endfunction

  function automatic logic [2:0] expOut();
    logic m;
    m = (mMode == "RUN") && (!PWM_EN || ((runCycles % LEVELS) < winLevel));
    return {m && door_closed, mMode == "RUN", mMode == "PAUSE"};
  endfunction

  // Advances one clock and moves the model by the rules the inputs imply at that edge.
  task automatic tick();
    string nxt;
    @(posedge clk);
    if (!resetn) begin
      mMode = "IDLE";
    end else begin
      nxt = mMode;
      if (!clearn || timer_done) nxt = "IDLE";
      else if (!stopn || !door_closed) nxt = (mMode == "IDLE") ? "IDLE" : "PAUSE";
      else if (!startn) nxt = "RUN";
      if (nxt == "RUN") begin
        runCycles = (mMode == "RUN") ? runCycles + 1 : 0;
        if (runCycles % LEVELS == 0) winLevel = effLevel(int'(power_level));
      end
      mMode = nxt;
    end
    #1;
  endtask

  task automatic applyIdleInputs();
    startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; timer_done = 1'b0;
  endtask

  task automatic startRun(input int lvl);
    power_level = LEVEL_W'(lvl);
    startn = 1'b0;
    tick();
    startn = 1'b1;
  endtask

  task automatic test_reset();
    applyIdleInputs();
    power_level = '0;
    resetn = 1'b0;
    #2;
    testsRun++;
    if ({mag_on, running, paused} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL reset_state got %b want 000", {mag_on, running, paused});
    end
    @(negedge clk);
    resetn = 1'b1;
    startRun(0);
    tick();
    testsRun++;
    if ({mag_on, running, paused} !== 3'b110) begin
      testsFailed++;
      $display("[TB] FAIL pre_reset_run got %b want 110", {mag_on, running, paused});
    end
    #2;
    resetn = 1'b0;
    #1;
    testsRun++;
    if ({mag_on, running, paused} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL async_reset got %b want 000", {mag_on, running, paused});
    end
    tick();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    testsRun++;
    if ({mag_on, running, paused} !== expOut() || mMode != "IDLE") begin
      testsFailed++;
      $display("[TB] FAIL after_reset got %b want %b", {mag_on, running, paused}, expOut());
    end
  endtask

  task automatic test_full_power();
    startRun(0);
    testsRun++;
    if (running !== 1'b1 || mag_on !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL start_latency got run=%b mag=%b want 1 1", running, mag_on);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      testsRun++;
      if ({mag_on, running, paused} !== 3'b110) begin
        testsFailed++;
        $display("[TB] FAIL full_power cyc%0d got %b want 110", i, {mag_on, running, paused});
      end
    end
    clearn = 1'b0;
    tick();
    clearn = 1'b1;
  endtask

  task automatic test_level_change();
    bit changed = 1'b0;
    startRun(3);
    for (int i = 0; i < 45; i++) begin
      testsRun++;
      if ({mag_on, running, paused} !== expOut()) begin
        testsFailed++;
        $display("[TB] FAIL level_duty cyc%0d got %b want %b", i, {mag_on, running, paused}, expOut());
      end
      if (!changed && (runCycles % LEVELS) == 5) begin
        power_level = LEVEL_W'(7);
        changed = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_door();
    door_closed = 1'b0;
    #1;
    testsRun++;
    if (mag_on !== 1'b0 || running !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL door_gate got mag=%b run=%b want 0 1", mag_on, running);
    end
    tick();
    testsRun++;
    if ({mag_on, running, paused} !== 3'b001) begin
      testsFailed++;
      $display("[TB] FAIL door_pause got %b want 001", {mag_on, running, paused});
    end
    door_closed = 1'b1;
    tick();
    power_level = LEVEL_W'(4);
    startn = 1'b0;
    tick();
    startn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      testsRun++;
      if ({mag_on, running, paused} !== expOut() || runCycles !== i) begin
        testsFailed++;
        $display("[TB] FAIL resume_window cyc%0d got %b want %b", i, {mag_on, running, paused}, expOut());
      end
      tick();
    end
  endtask

  task automatic test_priority();
    clearn = 1'b0;
    tick();
    clearn = 1'b1;
    startn = 1'b0; stopn = 1'b0;
    tick();
    testsRun++;
    if ({mag_on, running, paused} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL start_vs_stop got %b want 000", {mag_on, running, paused});
    end
    stopn = 1'b1;
    tick();
    startn = 1'b1;
    timer_done = 1'b1; stopn = 1'b0;
    tick();
    testsRun++;
    if ({mag_on, running, paused} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL timer_vs_stop got %b want 000", {mag_on, running, paused});
    end
    timer_done = 1'b0; stopn = 1'b1;
    startRun(5);
    stopn = 1'b0;
    tick();
    stopn = 1'b1;
    testsRun++;
    if ({mag_on, running, paused} !== 3'b001) begin
      testsFailed++;
      $display("[TB] FAIL stop_pause got %b want 001", {mag_on, running, paused});
    end
    clearn = 1'b0;
    tick();
    clearn = 1'b1;
    testsRun++;
    if ({mag_on, running, paused} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL clear_pause got %b want 000", {mag_on, running, paused});
    end
  endtask

  task automatic test_clamp();
    startRun(15);
    for (int i = 0; i < 25; i++) begin
      testsRun++;
      if ({mag_on, running, paused} !== 3'b110) begin
        testsFailed++;
        $display("[TB] FAIL clamp_15 cyc%0d got %b want 110", i, {mag_on, running, paused});
      end
      tick();
    end
    clearn = 1'b0;
    tick();
    clearn = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      startn      = ($urandom_range(0, 99) >= 30);
      stopn       = ($urandom_range(0, 99) >= 8);
      clearn      = ($urandom_range(0, 99) >= 3);
      door_closed = ($urandom_range(0, 99) >= 8);
      timer_done  = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 10) power_level = LEVEL_W'($urandom_range(0, 15));
      tick();
      testsRun++;
      if ({mag_on, running, paused} !== expOut()) begin
        testsFailed++;
        $display("[TB] FAIL random cyc%0d got %b want %b", i, {mag_on, running, paused}, expOut());
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_power();
    test_level_change();
    test_door();
    test_priority();
    test_clamp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
